contador_pontos_param: RTL and testbench

Parametrised score counter for the game datapath: a synchronous, single-clock successor of the fixed 6-bit score counter. It converts level-valued `acertou`/`errou` strobes into one score event per rising edge, applies saturation and a consecutive-hit bonus, and derives the number of active blocking lines with hysteresis. It also emits one-cycle pulses whenever a line is added or removed. It sits between the round-judging FSM and the blocking-line renderer.

---
 rtl/contador_pontos_param_if.sv | 29 ++
 rtl/contador_pontos_param.sv | 110 +++++++++++
 tb/tb_contador_pontos_param.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/contador_pontos_param_if.sv
// Control/status bundle between the round-judging FSM and the score counter.
// The master drives the score strobes; the slave (the counter) drives score and line status.
interface contador_pontos_param_if #(
  parameter int LARGURA  = 6,
  parameter int N_LINHAS = 7
);
  localparam int LW = $clog2(N_LINHAS + 1);

  logic               zera;
  logic               enable;
  logic               acertou;
  logic               errou;
  logic [LARGURA-1:0] pontos;
  logic [LW-1:0]      linhas_bloq;
  logic               sobe_linha;
  logic               desce_linha;
  logic               pontuacao_maxima;
  logic               em_sequencia;

  modport master (
    output zera, enable, acertou, errou,
    input  pontos, linhas_bloq, sobe_linha, desce_linha, pontuacao_maxima, em_sequencia
  );

  modport slave (
    input  zera, enable, acertou, errou,
    output pontos, linhas_bloq, sobe_linha, desce_linha, pontuacao_maxima, em_sequencia
  );
endinterface

// File: rtl/contador_pontos_param.sv
// Saturating score counter with hit-streak bonus and hysteretic blocking-line count.
// Score follows input edges at the same clock edge; lines lag the score by one cycle.
module contador_pontos_param #(
  parameter int LARGURA    = 6,
  parameter int PONTOS_MAX = 32,
  parameter int PASSO      = 4,
  parameter int N_LINHAS   = 7,
  parameter int HISTERESE  = 1,
  parameter int SEQ_BONUS  = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  contador_pontos_param_if.slave bus
);

  localparam int LW = $clog2(N_LINHAS + 1);
  localparam int SW = (SEQ_BONUS > 0) ? $clog2(SEQ_BONUS + 1) : 1;
  localparam int TW = 32;
  localparam bit BONUS_ON = (SEQ_BONUS != 0);
  localparam logic [SW-1:0]      SEQ_SAT = SW'(SEQ_BONUS);
  localparam logic [LARGURA-1:0] PMAX    = LARGURA'(PONTOS_MAX);
  localparam logic [LW-1:0]      LMAX    = LW'(N_LINHAS);

  function automatic logic [LARGURA-1:0] sat_add(input logic [LARGURA-1:0] p,
                                                 input logic [1:0]         inc);
    logic [LARGURA:0] s;
    s = {1'b0, p} + (LARGURA+1)'(inc);
    sat_add = (s > {1'b0, PMAX}) ? PMAX : s[LARGURA-1:0];
  endfunction

  function automatic logic [LARGURA-1:0] sat_dec(input logic [LARGURA-1:0] p);
    sat_dec = (p == '0) ? '0 : p - 1'b1;
  endfunction

  logic               acertou_d, errou_d;
  logic [LARGURA-1:0] pontos_q, pontos_n;
  logic [SW-1:0]      seq_q, seq_n;
  logic [LW-1:0]      linhas_q, linhas_n;
  logic               sobe_q, sobe_n, desce_q, desce_n;
  logic               ev_a, ev_e, bonus;
  logic [1:0]         inc;
  logic [TW-1:0]      pontos_ext, lim_sobe, lim_desce;

  assign ev_a       = bus.acertou & ~acertou_d;
  assign ev_e       = bus.errou & ~errou_d;
  assign bonus      = BONUS_ON && (seq_q >= SEQ_SAT);
  assign inc        = bonus ? 2'd2 : 2'd1;
  // Thresholds are evaluated in a wide domain so PASSO*N_LINHAS never wraps.
  assign pontos_ext = TW'(pontos_q);
  assign lim_sobe   = TW'(PASSO) * (TW'(linhas_q) + TW'(1));
  assign lim_desce  = TW'(PASSO) * TW'(linhas_q);

  always_comb begin
    pontos_n = pontos_q;
    seq_n    = seq_q;
    linhas_n = linhas_q;
    sobe_n   = 1'b0;
    desce_n  = 1'b0;
    if (bus.zera) begin
      pontos_n = '0;
      seq_n    = '0;
      linhas_n = '0;
    end else begin
      // Simultaneous hit and miss cancel out.
      if (bus.enable && ev_a && !ev_e) begin
        pontos_n = sat_add(pontos_q, inc);
        seq_n    = (seq_q >= SEQ_SAT) ? seq_q : seq_q + 1'b1;
      end else if (bus.enable && ev_e && !ev_a) begin
        pontos_n = sat_dec(pontos_q);
        seq_n    = '0;
      end

      if ((linhas_q < LMAX) && (pontos_ext >= lim_sobe)) begin
        linhas_n = linhas_q + 1'b1;
        sobe_n   = 1'b1;
      end else if ((linhas_q != '0) && (pontos_ext + TW'(HISTERESE) < lim_desce)) begin
        linhas_n = linhas_q - 1'b1;
        desce_n  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acertou_d <= 1'b0;
      errou_d   <= 1'b0;
      pontos_q  <= '0;
      seq_q     <= '0;
      linhas_q  <= '0;
      sobe_q    <= 1'b0;
      desce_q   <= 1'b0;
    end else begin
      acertou_d <= bus.acertou;
      errou_d   <= bus.errou;
      pontos_q  <= pontos_n;
      seq_q     <= seq_n;
      linhas_q  <= linhas_n;
      sobe_q    <= sobe_n;
      desce_q   <= desce_n;
    end
  end

  assign bus.pontos           = pontos_q;
  assign bus.linhas_bloq      = linhas_q;
  assign bus.sobe_linha       = sobe_q;
  assign bus.desce_linha      = desce_q;
  assign bus.pontuacao_maxima = (pontos_q == PMAX);
  assign bus.em_sequencia     = bonus;

endmodule

// File: tb/tb_contador_pontos_param.sv
// Directed bench for contador_pontos_param: vector table plus hand-written multi-cycle sequences.
module tb_contador_pontos_param;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  contador_pontos_param_if #(.LARGURA(6), .N_LINHAS(7)) bus ();

  contador_pontos_param #(
    .LARGURA(6), .PONTOS_MAX(32), .PASSO(4), .N_LINHAS(7), .HISTERESE(1), .SEQ_BONUS(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int en, a, e, z;
    int p, l, s, d, mx, em;
  } vec_t;

  vec_t tbl [20];
  int n_tests = 0;
  int n_fail  = 0;
  int sobe_cnt, desce_cnt;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int p, input int l, input int s,
                         input int d, input int mx, input int em);
    chk({nm, ".pontos"}, int'(bus.pontos), p);
    chk({nm, ".linhas_bloq"}, int'(bus.linhas_bloq), l);
    chk({nm, ".sobe_linha"}, int'(bus.sobe_linha), s);
    chk({nm, ".desce_linha"}, int'(bus.desce_linha), d);
    chk({nm, ".pontuacao_maxima"}, int'(bus.pontuacao_maxima), mx);
    chk({nm, ".em_sequencia"}, int'(bus.em_sequencia), em);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (bus.sobe_linha)  sobe_cnt++;
    if (bus.desce_linha) desce_cnt++;
  endtask

  task automatic hit();
    bus.acertou = 1'b1; tick();
    bus.acertou = 1'b0; tick();
  endtask

  task automatic miss();
    bus.errou = 1'b1; tick();
    bus.errou = 1'b0; tick();
  endtask

  // Expected score after k hits from zero with an unbroken streak.
  function automatic int sat_exp(input int k);
    int v;
    v = (k <= 3) ? k : 3 + 2 * (k - 3);
    return (v > 32) ? 32 : v;
  endfunction

  initial begin
    //           en a  e  z  p  l  s  d  mx em
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 1, 0, 0, 2, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 2, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 1, 0, 0, 3, 0, 0, 0, 0, 1};
    tbl[6]  = '{1, 0, 0, 0, 3, 0, 0, 0, 0, 1};
    tbl[7]  = '{1, 1, 0, 0, 5, 0, 0, 0, 0, 1};
    tbl[8]  = '{1, 0, 0, 0, 5, 1, 1, 0, 0, 1};
    tbl[9]  = '{1, 0, 0, 0, 5, 1, 0, 0, 0, 1};
    tbl[10] = '{1, 0, 1, 0, 4, 1, 0, 0, 0, 0};
    tbl[11] = '{1, 0, 0, 0, 4, 1, 0, 0, 0, 0};
    tbl[12] = '{1, 0, 1, 0, 3, 1, 0, 0, 0, 0};
    tbl[13] = '{1, 0, 0, 0, 3, 1, 0, 0, 0, 0};
    tbl[14] = '{1, 0, 1, 0, 2, 1, 0, 0, 0, 0};
    tbl[15] = '{1, 0, 0, 0, 2, 0, 0, 1, 0, 0};
    tbl[16] = '{1, 0, 0, 0, 2, 0, 0, 0, 0, 0};
    tbl[17] = '{1, 1, 1, 0, 2, 0, 0, 0, 0, 0};
    tbl[18] = '{1, 1, 1, 0, 2, 0, 0, 0, 0, 0};
    tbl[19] = '{1, 0, 0, 0, 2, 0, 0, 0, 0, 0};

    sobe_cnt = 0; desce_cnt = 0;
    reset = 1'b1;
    bus.zera = 1'b0; bus.enable = 1'b1; bus.acertou = 1'b0; bus.errou = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Bonus, line up, hysteresis, simultaneous edges.
    for (int i = 0; i < 20; i++) begin
      bus.enable  = 1'(tbl[i].en);
      bus.acertou = 1'(tbl[i].a);
      bus.errou   = 1'(tbl[i].e);
      bus.zera    = 1'(tbl[i].z);
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].p, tbl[i].l, tbl[i].s, tbl[i].d,
              tbl[i].mx, tbl[i].em);
    end

    // Held acertou scores once.
    bus.acertou = 1'b1;
    repeat (10) tick();
    chk("held.pontos", int'(bus.pontos), 3);
    bus.acertou = 1'b0;
    tick();

    // Saturation and line cap.
    bus.zera = 1'b1; tick(); bus.zera = 1'b0;
    chk_all("zera0", 0, 0, 0, 0, 0, 0);
    sobe_cnt = 0; desce_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      bus.acertou = 1'b1; tick();
      chk($sformatf("sat%0d.pontos", k), int'(bus.pontos), sat_exp(k));
      bus.acertou = 1'b0; tick();
    end
    repeat (4) tick();
    chk("sat.linhas_bloq", int'(bus.linhas_bloq), 7);
    chk("sat.sobe_count", sobe_cnt, 7);
    chk("sat.desce_count", desce_cnt, 0);
    chk("sat.pontuacao_maxima", int'(bus.pontuacao_maxima), 1);
    hit(); hit();
    repeat (3) tick();
    chk("sat_more.pontos", int'(bus.pontos), 32);
    chk("sat_more.sobe_count", sobe_cnt, 7);
    miss();
    chk("sat_miss.pontos", int'(bus.pontos), 31);
    chk("sat_miss.pontuacao_maxima", int'(bus.pontuacao_maxima), 0);
    chk("sat_miss.linhas_bloq", int'(bus.linhas_bloq), 7);

    // zera from pontos=12, linhas=3.
    bus.zera = 1'b1; tick(); bus.zera = 1'b0;
    repeat (8) hit();
    miss();
    repeat (2) tick();
    chk("pre_zera.pontos", int'(bus.pontos), 12);
    chk("pre_zera.linhas_bloq", int'(bus.linhas_bloq), 3);
    desce_cnt = 0;
    bus.zera = 1'b1; tick();
    chk_all("zera", 0, 0, 0, 0, 0, 0);
    bus.zera = 1'b0;
    repeat (3) tick();
    chk("post_zera.linhas_bloq", int'(bus.linhas_bloq), 0);
    chk("post_zera.desce_count", desce_cnt, 0);

    // Enable gating, including an input already high when enable rises.
    bus.enable = 1'b0; bus.acertou = 1'b1; tick();
    chk("en0.pontos", int'(bus.pontos), 0);
    tick();
    bus.enable = 1'b1; tick();
    chk("en_rise_held.pontos", int'(bus.pontos), 0);
    tick();
    chk("en_rise_held2.pontos", int'(bus.pontos), 0);
    bus.acertou = 1'b0; tick();
    miss();
    chk("miss_at_zero.pontos", int'(bus.pontos), 0);

    // Asynchronous reset between edges with pontos=9.
    repeat (6) hit();
    repeat (2) tick();
    chk("pre_rst.pontos", int'(bus.pontos), 9);
    chk("pre_rst.linhas_bloq", int'(bus.linhas_bloq), 2);
    chk("pre_rst.em_sequencia", int'(bus.em_sequencia), 1);
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0);

    // acertou high at reset release counts once.
    bus.acertou = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("rel_held.pontos", int'(bus.pontos), 1);
    tick();
    chk("rel_held2.pontos", int'(bus.pontos), 1);
    bus.acertou = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
